// File: rtl/quadrature_gen.sv
// quadrature_gen: quadrature (A/B) signal generator.
// Walks a registered position toward `target`, one quarter-step every
// max(step_period,1) clocks, and drives the matching Gray-coded A/B lines.
// Direction comes from the sign of (target - position) mod 2^w. A tie at
// 2^(w-1) decrements.
// Optional feature: define QUADRATURE_GEN_BOUNCE_EN to add contact-bounce
// chatter on the line that changed after each step. It lasts bounce_len
// cycles. Without the macro, a/b are always the clean code.
module quadrature_gen #(
  parameter int w          = 16,
  parameter int pw         = 24,
  parameter int bounce_len = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [w-1:0]  target,
  input  logic [pw-1:0] step_period,
  output logic          a,
  output logic          b,
  output logic [w-1:0]  position,
  output logic          dir,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } mode_t;

  localparam logic [w-1:0]  W_ONE  = {{(w-1){1'b0}}, 1'b1};
  localparam logic [pw-1:0] PW_ONE = {{(pw-1){1'b0}}, 1'b1};

  mode_t         mode_s;
  logic [w-1:0]  pos_r;
  logic [w-1:0]  pos_nxt_s;
  logic [w-1:0]  diff_s;
  logic [pw-1:0] tmr_r;
  logic [pw-1:0] period_s;
  logic          step_s;
  logic          inc_s;
  logic          dir_r;
  logic          a_r;
  logic          b_r;
  logic [1:0]    ab_new_s;

  // Clean quadrature code for a position, returned as {a, b}
  function automatic logic [1:0] quad_code(input logic [w-1:0] p);
    return {p[1] ^ p[0], p[1]};
  endfunction

  // Operating mode: at target -> idle, otherwise run or hold on en
  always_comb begin
    mode_s = ST_IDLE;
    if (pos_r == target) begin
      mode_s = ST_IDLE;
    end else if (en) begin
      mode_s = ST_RUN;
    end else begin
      mode_s = ST_HOLD;
    end
  end

  // Step decision: interval elapsed (>= so a lowered period steps at once)
  always_comb begin
    period_s  = (step_period == {pw{1'b0}}) ? PW_ONE : step_period;
    diff_s    = target - pos_r;
    inc_s     = ~diff_s[w-1];
    step_s    = 1'b0;
    pos_nxt_s = pos_r;
    if ((mode_s == ST_RUN) &&
        (({1'b0, tmr_r} + {{pw{1'b0}}, 1'b1}) >= {1'b0, period_s})) begin
      step_s    = 1'b1;
      pos_nxt_s = inc_s ? (pos_r + W_ONE) : (pos_r - W_ONE);
    end else begin
      step_s    = 1'b0;
      pos_nxt_s = pos_r;
    end
    ab_new_s = quad_code(pos_nxt_s);
  end

  // Interval timer, position and direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_r <= {pw{1'b0}};
      pos_r <= {w{1'b0}};
      dir_r <= 1'b0;
    end else begin
      case (mode_s)
        ST_IDLE: tmr_r <= {pw{1'b0}};
        ST_RUN: begin
          if (step_s) begin
            tmr_r <= {pw{1'b0}};
            pos_r <= pos_nxt_s;
            dir_r <= inc_s;
          end else begin
            tmr_r <= tmr_r + PW_ONE;
          end
        end
        ST_HOLD: tmr_r <= tmr_r;
        default: tmr_r <= {pw{1'b0}};
      endcase
    end
  end

`ifdef QUADRATURE_GEN_BOUNCE_EN
  localparam int bw = $clog2(bounce_len + 2);
  localparam logic [bw-1:0] B_LAST  = bw'(bounce_len);
  localparam logic [bw-1:0] B_START = (bounce_len > 0) ? bw'(1) : bw'(0);

  logic [bw-1:0] bcnt_r;
  logic [1:0]    bmask_r;
  logic [1:0]    ab_old_s;

  // Clean code of the current position, which is the reference while chattering
  always_comb begin
    ab_old_s = quad_code(pos_r);
  end

  // Phase lines with chatter: line that changed shows new ^ (k odd), k = 1..bounce_len
  always_ff @(posedge clk) begin
    if (reset) begin
      {a_r, b_r} <= 2'b00;
      bcnt_r     <= {bw{1'b0}};
      bmask_r    <= 2'b00;
    end else if (step_s) begin
      {a_r, b_r} <= ab_new_s;
      bmask_r    <= ab_new_s ^ ab_old_s;
      bcnt_r     <= B_START;
    end else if (bcnt_r != {bw{1'b0}}) begin
      {a_r, b_r} <= ab_old_s ^ (bmask_r & {2{bcnt_r[0]}});
      bcnt_r     <= (bcnt_r == B_LAST) ? {bw{1'b0}} : (bcnt_r + bw'(1));
    end else begin
      {a_r, b_r} <= ab_old_s;
    end
  end
`else
  // Phase lines: clean Gray code of the position being registered
  always_ff @(posedge clk) begin
    if (reset) begin
      {a_r, b_r} <= 2'b00;
    end else begin
      {a_r, b_r} <= ab_new_s;
    end
  end
`endif

  assign a        = a_r;
  assign b        = b_r;
  assign position = pos_r;
  assign dir      = dir_r;
  assign busy     = (pos_r != target);

endmodule

// File: tb/tb_quadrature_gen.sv
// Testbench for quadrature_gen. An integer model tracks position and the
// interval timer, and a lookup table gives the A/B code. A negedge process
// compares every output each cycle. Directed scenarios also pin literal values.
module tb_quadrature_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] target;
  logic [23:0] step_period;
  logic        a;
  logic        b;
  logic [15:0] position;
  logic        dir;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state
  int m_pos = 0;
  int m_tmr = 0;
  bit m_dir = 1'b0;

  // AB code per position mod 4: 00 -> 10 -> 11 -> 01 (A leads B going up)
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] fwd_ab [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};

  quadrature_gen #(.w(16), .pw(24), .bounce_len(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .target      (target),
    .step_period (step_period),
    .a           (a),
    .b           (b),
    .position    (position),
    .dir         (dir),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: one quarter-step whenever a full interval has elapsed
  always @(posedge clk) begin : model
    int p;
    int d;
    if (reset) begin
      m_pos <= 0;
      m_tmr <= 0;
      m_dir <= 1'b0;
    end else if (m_pos == int'(target)) begin
      m_tmr <= 0;
    end else if (en) begin
      p = (step_period == 24'd0) ? 1 : int'(step_period);
      if (m_tmr + 1 >= p) begin
        d = (int'(target) - m_pos + 65536) % 65536;
        if (d < 32768) begin
          m_pos <= (m_pos + 1) % 65536;
          m_dir <= 1'b1;
        end else begin
          m_pos <= (m_pos + 65535) % 65536;
          m_dir <= 1'b0;
        end
        m_tmr <= 0;
      end else begin
        m_tmr <= m_tmr + 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("position", position, m_pos);
      chk("a", a, ab_tab[m_pos % 4][1]);
      chk("b", b, ab_tab[m_pos % 4][0]);
      chk("dir", dir, m_dir);
      chk("busy", busy, (m_pos != int'(target)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_pos(input int v, input int budget);
    int k;
    k = 0;
    while (position !== 16'(v) && k < budget) begin
      tick();
      k++;
    end
    chk("wait_pos", position, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; target = 16'd7; step_period = 24'd4;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_pos", position, 32'd0);
    chk("rst_ab", {a, b}, 32'd0);
    chk("rst_dir", dir, 32'd0);
    chk("rst_busy1", busy, 32'd1);
    target = 16'd0;
    #1;
    chk("rst_busy0", busy, 32'd0);

    // Forward run: steps at edges 4, 8, 12, 16, 20
    reset = 1'b0; target = 16'd5; step_period = 24'd4; en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) chk("fwd_wait", position, 32'd0);
      if (k % 4 == 0) begin
        chk("fwd_pos", position, k / 4);
        chk("fwd_ab", {a, b}, fwd_ab[k / 4 - 1]);
      end
    end
    chk("fwd_dir", dir, 32'd1);
    chk("fwd_busy", busy, 32'd0);

    // Back to 0 at one step per clock
    target = 16'd0; step_period = 24'd1;
    repeat (5) tick();
    chk("back_pos", position, 32'd0);
    chk("back_dir", dir, 32'd0);

    // Wrap downward
    target = 16'hFFFE;
    tick();
    chk("wrapdn_pos1", position, 32'hFFFF);
    chk("wrapdn_ab1", {a, b}, 32'b01);
    tick();
    chk("wrapdn_pos2", position, 32'hFFFE);
    chk("wrapdn_ab2", {a, b}, 32'b11);
    chk("wrapdn_dir", dir, 32'd0);
    chk("wrapdn_busy", busy, 32'd0);

    // Wrap upward
    target = 16'd1;
    repeat (3) tick();
    chk("wrapup_pos", position, 32'd1);
    chk("wrapup_dir", dir, 32'd1);

    // Tie case: diff = 0x8000 decrements
    target = 16'h8001;
    tick();
    chk("tie_pos", position, 32'd0);
    chk("tie_dir", dir, 32'd0);
    target = 16'd0;
    #1;
    chk("tie_busy", busy, 32'd0);

    // Lowering the period mid-interval steps immediately
    target = 16'd3; step_period = 24'd10;
    repeat (5) tick();
    chk("lower_wait", position, 32'd0);
    step_period = 24'd2;
    tick();
    chk("lower_pos", position, 32'd1);
    repeat (4) tick();
    chk("lower_end", position, 32'd3);

    // Hold and retarget
    target = 16'd0; step_period = 24'd1;
    repeat (3) tick();
    target = 16'd100; step_period = 24'd3;
    wait_pos(2, 20);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_pos", position, 32'd2);
    end
    en = 1'b1;
    wait_pos(4, 20);
    target = 16'd0;
    wait_pos(0, 40);
    chk("ret_dir", dir, 32'd0);
    chk("ret_busy", busy, 32'd0);

    // Reset mid-motion with step_period = 0
    step_period = 24'd0; target = 16'd8;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("p0_pos", position, k);
    end
    reset = 1'b1;
    tick();
    chk("mrst_pos", position, 32'd0);
    chk("mrst_ab", {a, b}, 32'd0);
    chk("mrst_dir", dir, 32'd0);
    reset = 1'b0;
    #1;
    chk("mrst_busy", busy, 32'd1);
    tick();
    chk("mrst_resume", position, 32'd1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
